// File: rtl/sccb_arbiter.sv
// Two-port register-write arbiter that serializes requests onto one SCCB interface master.
// Optional macro SCCB_ARB_RR_EN: round-robin tie-break instead of fixed port-0 priority.
module sccb_arbiter #(
  parameter int CLK_FREQ   = 25000000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_start,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_start,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_done,
  input  logic       sccb_ready,
  output logic       sccb_start,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_data,
  output logic       grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int          TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam logic [31:0] WDOG_LAST      = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        pend0_q, pend1_q;
  logic [7:0]  addr0_q, data0_q, addr1_q, data1_q;
  logic [31:0] wdog_q;
  logic        start_q, done0_q, done1_q, grant_q, busy_q, terr_q;
  logic [7:0]  saddr_q, sdata_q;
  logic        win_s, tie_s, finish_s, expire_s;

`ifdef SCCB_ARB_RR_EN
  // Last grant starts as port 1 so that port 0 wins the first tie after reset.
  logic last_q;
  assign tie_s = ~last_q;
`else
  assign tie_s = 1'b0;
`endif

  // Winner among pending ports; only consulted when at least one is pending.
  always_comb begin
    win_s = 1'b0;
    if (pend0_q && pend1_q) begin
      win_s = tie_s;
    end else if (pend0_q) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // End of the in-flight transaction: normal completion or watchdog expiry.
  always_comb begin
    finish_s = 1'b0;
    expire_s = 1'b0;
    if (state_q == ST_IDLE) begin
      finish_s = 1'b0;
      expire_s = 1'b0;
    end else if (wdog_q == WDOG_LAST) begin
      finish_s = 1'b1;
      expire_s = 1'b1;
    end else if ((state_q == ST_WAIT_DONE) && sccb_ready) begin
      finish_s = 1'b1;
      expire_s = 1'b0;
    end else begin
      finish_s = 1'b0;
      expire_s = 1'b0;
    end
  end

  // Holding registers, arbitration FSM, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      addr0_q <= 8'd0;
      data0_q <= 8'd0;
      addr1_q <= 8'd0;
      data1_q <= 8'd0;
      wdog_q  <= 32'd0;
      start_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      saddr_q <= 8'd0;
      sdata_q <= 8'd0;
`ifdef SCCB_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      start_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (req0_start && !pend0_q) begin
        pend0_q <= 1'b1;
        addr0_q <= req0_addr;
        data0_q <= req0_data;
      end
      if (req1_start && !pend1_q) begin
        pend1_q <= 1'b1;
        addr1_q <= req1_addr;
        data1_q <= req1_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (sccb_ready && (pend0_q || pend1_q)) begin
            grant_q <= win_s;
            saddr_q <= win_s ? addr1_q : addr0_q;
            sdata_q <= win_s ? data1_q : data0_q;
            start_q <= 1'b1;
            wdog_q  <= 32'd0;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_BUSY;
`ifdef SCCB_ARB_RR_EN
            last_q  <= win_s;
`endif
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (finish_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (grant_q) begin
              pend1_q <= 1'b0;
              done1_q <= 1'b1;
            end else begin
              pend0_q <= 1'b0;
              done0_q <= 1'b1;
            end
            if (expire_s) begin
              terr_q <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + 32'd1;
            if ((state_q == ST_WAIT_BUSY) && !sccb_ready) begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready  = ~pend0_q;
  assign req1_ready  = ~pend1_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign sccb_start  = start_q;
  assign sccb_addr   = saddr_q;
  assign sccb_data   = sdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter with a behavioural SCCB master model.
module tb_sccb_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_start = 1'b0, req1_start = 1'b0;
  logic [7:0] req0_addr = 8'd0, req0_data = 8'd0, req1_addr = 8'd0, req1_data = 8'd0;
  logic       req0_ready, req0_done, req1_ready, req1_done;
  logic       sccb_ready = 1'b1;
  logic       sccb_start, grant, busy, timeout_err;
  logic [7:0] sccb_addr, sccb_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  int   done0_cnt = 0;
  int   done1_cnt = 0;
  int   model_cnt = 0;
  bit   model_hang = 1'b0;
  bit   last_model = 1'b1;
  logic [7:0] log_addr [0:31];
  logic [7:0] log_data [0:31];
  logic       log_grant[0:31];

  sccb_arbiter #(.CLK_FREQ(1000000), .TIMEOUT_MS(1)) dut (
    .clk(clk), .rst(rst),
    .req0_start(req0_start), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_start(req1_start), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start),
    .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // SCCB master model: drops ready the cycle after an issue and holds it low 20 cycles.
  always @(posedge clk) begin
    if (sccb_start && !model_hang) begin
      sccb_ready <= 1'b0;
      model_cnt  <= 20;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) sccb_ready <= 1'b1;
    end
  end

  // Issue log and done-pulse counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sccb_start) begin
      log_addr[issue_cnt % 32]  <= sccb_addr;
      log_data[issue_cnt % 32]  <= sccb_data;
      log_grant[issue_cnt % 32] <= grant;
      issue_cnt <= issue_cnt + 1;
    end
    if (req0_done) done0_cnt <= done0_cnt + 1;
    if (req1_done) done1_cnt <= done1_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      if (!busy && req0_ready && req1_ready && sccb_ready && model_cnt == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int port, input int limit, output bit ok, output int dcyc);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((port == 0 && req0_done) || (port == 1 && req1_done)) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1 || req0_done !== 1'b0 || req1_done !== 1'b0 ||
        sccb_start !== 1'b0 || sccb_addr !== 8'h00 || sccb_data !== 8'h00 || grant !== 1'b0 ||
        busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b%b done=%b%b start=%b addr=%h data=%h grant=%b busy=%b terr=%b, required rdy=11 done=00 rest 0",
               req0_ready, req1_ready, req0_done, req1_done, sccb_start, sccb_addr, sccb_data, grant, busy, timeout_err);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || sccb_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b start=%b, required 0 0", busy, sccb_start);
    end
  endtask

  task automatic test_single();
    int i0, d0, d1, dc;
    bit ok;
    i0 = issue_cnt; d0 = done0_cnt; d1 = done1_cnt;
    req0_addr = 8'h12; req0_data = 8'h80; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    checks++;
    if (req0_ready !== 1'b0 || sccb_start !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: ready0=%b start=%b, required 0 0", req0_ready, sccb_start);
    end
    tick();
    checks++;
    if (sccb_start !== 1'b1 || sccb_addr !== 8'h12 || sccb_data !== 8'h80 || grant !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: start=%b addr=%h data=%h grant=%b busy=%b, required 1 12 80 0 1",
               sccb_start, sccb_addr, sccb_data, grant, busy);
    end
    tick();
    checks++;
    if (sccb_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: start=%b, required 0", sccb_start);
    end
    wait_done(0, 300, ok, dc);
    checks++;
    if (ok !== 1'b1 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done: seen=%b ready0=%b, required 1 1", ok, req0_ready);
    end
    wait_quiet(ok);
    checks++;
    if (ok !== 1'b1 || issue_cnt - i0 != 1 || done0_cnt - d0 != 1 || done1_cnt - d1 != 0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_counts: quiet=%b issues=%0d done0=%0d done1=%0d ready1=%b, required 1 1 1 0 1",
               ok, issue_cnt - i0, done0_cnt - d0, done1_cnt - d1, req1_ready);
    end
    last_model = 1'b0;
  endtask

  task automatic test_tie();
    int i0, ds;
    bit ok, first;
    for (int r = 0; r < 2; r++) begin
`ifdef SCCB_ARB_RR_EN
      first = ~last_model;
`else
      first = 1'b0;
`endif
      i0 = issue_cnt; ds = done0_cnt + done1_cnt;
      req0_addr = 8'h3A; req0_data = 8'h04; req0_start = 1'b1;
      req1_addr = 8'h40; req1_data = 8'hD0; req1_start = 1'b1;
      tick();
      req0_start = 1'b0; req1_start = 1'b0;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL tie_capture: ready=%b%b, required 00", req0_ready, req1_ready);
      end
      for (int i = 0; i < 300 && (done0_cnt + done1_cnt - ds) < 2; i++) tick();
      wait_quiet(ok);
      checks++;
      if (ok !== 1'b1 || issue_cnt - i0 != 2 ||
          log_grant[i0 % 32] !== first || log_grant[(i0 + 1) % 32] !== ~first ||
          log_addr[i0 % 32] !== (first ? 8'h40 : 8'h3A) || log_data[i0 % 32] !== (first ? 8'hD0 : 8'h04) ||
          log_addr[(i0 + 1) % 32] !== (first ? 8'h3A : 8'h40)) begin
        errors++;
        $display("FAIL tie_order round %0d: issues=%0d grants=%b,%b addr=%h,%h, required 2 grants=%b,%b",
                 r, issue_cnt - i0, log_grant[i0 % 32], log_grant[(i0 + 1) % 32],
                 log_addr[i0 % 32], log_addr[(i0 + 1) % 32], first, ~first);
      end
      last_model = ~first;
    end
  endtask

  task automatic test_ignore();
    int i0;
    bit ok;
    i0 = issue_cnt;
    req1_addr = 8'h41; req1_data = 8'hAA; req1_start = 1'b1;
    tick();
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignore_pending: ready1=%b, required 0", req1_ready);
    end
    req1_addr = 8'h42; req1_data = 8'h55;
    tick();
    req1_start = 1'b0;
    wait_quiet(ok);
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (ok !== 1'b1 || issue_cnt - i0 != 1 || log_addr[i0 % 32] !== 8'h41 || log_data[i0 % 32] !== 8'hAA) begin
      errors++;
      $display("FAIL ignore_busy_start: issues=%0d addr=%h data=%h, required 1 41 AA",
               issue_cnt - i0, log_addr[i0 % 32], log_data[i0 % 32]);
    end
    last_model = 1'b1;
  endtask

  task automatic test_timeout();
    int s, dc;
    bit ok;
    model_hang = 1'b1;
    req0_addr = 8'h11; req0_data = 8'h22; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    tick();
    checks++;
    if (sccb_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_issue: start=%b, required 1", sccb_start);
    end
    s = cyc;
    wait_done(0, 1200, ok, dc);
    checks++;
    if (ok !== 1'b1 || dc - s != 1000) begin
      errors++;
      $display("FAIL timeout_latency: seen=%b cycles=%0d, required 1 1000", ok, dc - s);
    end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flags: terr=%b busy=%b ready0=%b, required 1 0 1", timeout_err, busy, req0_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: terr=%b busy=%b, required 1 0", timeout_err, busy);
    end
    model_hang = 1'b0;
    last_model = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i0, d0, d1;
    bit ok;
    wait_quiet(ok);
    req0_addr = 8'h21; req0_data = 8'h31; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    req1_addr = 8'h50; req1_data = 8'h60; req1_start = 1'b1;
    tick();
    req1_start = 1'b0;
    checks++;
    if (ok !== 1'b1 || busy !== 1'b1 || sccb_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup: quiet=%b busy=%b sccb_ready=%b ready1=%b, required 1 1 0 0",
               ok, busy, sccb_ready, req1_ready);
    end
    i0 = issue_cnt; d0 = done0_cnt; d1 = done1_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1 || req0_done !== 1'b0 || req1_done !== 1'b0 ||
        sccb_start !== 1'b0 || sccb_addr !== 8'h00 || sccb_data !== 8'h00 || grant !== 1'b0 ||
        busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_values: rdy=%b%b done=%b%b start=%b addr=%h data=%h grant=%b busy=%b terr=%b, required rdy=11 rest 0",
               req0_ready, req1_ready, req0_done, req1_done, sccb_start, sccb_addr, sccb_data, grant, busy, timeout_err);
    end
    for (int i = 0; i < 60; i++) tick();
    checks++;
    if (issue_cnt - i0 != 0 || done0_cnt - d0 != 0 || done1_cnt - d1 != 0 || busy !== 1'b0 || sccb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_silent: issues=%0d done0=%0d done1=%0d busy=%b sccb_ready=%b, required 0 0 0 0 1",
               issue_cnt - i0, done0_cnt - d0, done1_cnt - d1, busy, sccb_ready);
    end
    last_model = 1'b1;
  endtask

  task automatic test_back_to_back();
    int dc;
    bit ok, found;
    req0_addr = 8'h6B; req0_data = 8'h0A; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    wait_done(0, 300, ok, dc);
    checks++;
    if (ok !== 1'b1 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: seen=%b ready0=%b, required 1 1", ok, req0_ready);
    end
    req0_addr = 8'h6C; req0_data = 8'h0B; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready0=%b, required 0", req0_ready);
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sccb_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (found !== 1'b1 || cyc - dc < 2 || sccb_addr !== 8'h6C || sccb_data !== 8'h0B) begin
      errors++;
      $display("FAIL b2b_reissue: found=%b gap=%0d addr=%h data=%h, required 1 >=2 6C 0B",
               found, cyc - dc, sccb_addr, sccb_data);
    end
    wait_done(0, 300, ok, dc);
    checks++;
    if (ok !== 1'b1 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: seen=%b ready0=%b, required 1 1", ok, req0_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_ignore();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Two-port write arbiter sharing a single SCCB interface master between the boot-time OV7670 register sequencer (port 0) and a runtime register-write source such as a debug/UART or exposure-tuning block (port 1). Each port sees a simple start/ready write handshake. The arbiter captures requests, serializes them onto the one SCCB interface, supervises each transaction with a watchdog, and reports completion per port. It sits between the requesters and the SCCB interface master, on the camera configuration clock.

## Interface
Parameters:
- CLK_FREQ, 25000000, clock frequency in Hz.
- TIMEOUT_MS, 10, watchdog limit per transaction in ms; TIMEOUT_CYCLES = CLK_FREQ/1000*TIMEOUT_MS, computed in 32-bit integer arithmetic.

Ports:
- clk  in  1  system clock; everything in this block is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_start  in  1  port 0 write-request pulse; sampled only while req0_ready=1.
- req0_addr  in  8  port 0 register address; captured with req0_start.
- req0_data  in  8  port 0 register data; captured with req0_start.
- req0_ready  out  1  port 0 can accept a request (no request pending).
- req0_done  out  1  one-cycle pulse when port 0's transaction completes or times out.
- req1_start / req1_addr / req1_data / req1_ready / req1_done: same widths and meaning for port 1.
- sccb_ready  in  1  SCCB interface master idle.
- sccb_start  out  1  one-cycle issue pulse to the SCCB interface master.
- sccb_addr  out  8  register address to the SCCB interface master.
- sccb_data  out  8  register data to the SCCB interface master.
- grant  out  1  index of the port currently or most recently granted.
- busy  out  1  high outside IDLE.
- timeout_err  out  1  sticky; set on any watchdog expiry; cleared only by rst.

## Operation
- Per-port holding register: pendingN, addrN, dataN. `reqN_start && reqN_ready` captures addr/data and sets pendingN. `reqN_ready = !pendingN`. A start while ready=0 is ignored.
- FSM states:
  - IDLE: leave when `sccb_ready && (pending0 || pending1)`. Select the winner, load sccb_addr/sccb_data from its holding register, drive sccb_start=1, set grant, clear wdog, go to WAIT_BUSY.
  - WAIT_BUSY: sccb_start=0. When sccb_ready=0, go to WAIT_DONE.
  - WAIT_DONE: when sccb_ready=1, clear pending[grant], pulse req[grant]_done, go to IDLE.
- Watchdog: counts every cycle in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1:
  - clear pending[grant];
  - pulse req[grant]_done;
  - set timeout_err;
  - go to IDLE.
- Default arbitration is fixed priority: port 0 wins when both ports are pending.
- sccb_addr/sccb_data hold their value between issues.

## Timing
- Reset values:
  - outputs: req0_ready=1, req1_ready=1; req*_done=0; sccb_start=0; sccb_addr=0; sccb_data=0; grant=0; busy=0; timeout_err=0.
  - internal: FSM=IDLE; pending cleared; wdog=0.
- Start-to-issue latency:
  - start in cycle t sets pending at t+1 and drops ready at t+1.
  - if IDLE and sccb_ready=1 at t+1, sccb_start is high during t+2, for exactly one cycle.
- Done to ready:
  - done pulses in the cycle after sccb_ready returns high in WAIT_DONE.
  - reqN_ready rises in that same cycle.
  - a start in the same cycle as done is accepted (ready already high).
- IDLE always requires sccb_ready=1 before issuing, so back-to-back issues are separated by at least one IDLE cycle.
- Simultaneous starts on both ports: both are captured; they are served one after the other in arbitration order.
- A new start on the non-granted port while busy is captured and does not disturb the in-flight transaction.
- Reset mid-operation: pending requests are discarded with no done pulse, and the FSM returns to IDLE. An SCCB transaction already in flight runs to completion on the interface master. The arbiter issues nothing further until sccb_ready=1.

## Configuration
- Macro: SCCB_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports are pending, the port that did not receive the last grant wins. After reset the last grant is treated as port 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties. Port 1 can be starved while port 0 keeps requests pending.

## Test plan
- Single port-0 write 0x12/0x80, with a model that holds sccb_ready low 20 cycles -> sccb_start pulses once with addr=0x12, data=0x80; req0_done pulses once; req0_ready=1 afterwards; req1 signals untouched.
- Both ports start in the same cycle (0x3A/0x04 on port 0, 0x40/0xD0 on port 1) -> without the macro, port 0 is issued first; with SCCB_ARB_RR_EN, a repeated tie alternates 0,1,0,1.
- req1_start while req1_ready=0 (data 0x55 over a pending 0xAA) -> 0xAA is issued; 0x55 is never issued.
- Model never drops sccb_ready after issue, with CLK_FREQ=1000000 and TIMEOUT_MS=1 -> after 1000 cycles req_done pulses, timeout_err=1 and stays 1, FSM returns to IDLE.
- rst asserted in WAIT_DONE with port 1 pending -> next cycle all outputs are at reset values; no done pulses; no sccb_start until a new request arrives.
- Port 0 restarts in the same cycle as its done pulse -> the request is accepted; the next sccb_start follows at least 2 cycles later.
